// File: rtl/uart_cmd_parser.sv
// Decodes 7-byte UART command frames (HEADER, CMD, D3..D0, CHK) into sine-generator
// control registers, with XOR checksum check, inter-byte timeout and error counting.
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          TIMEOUT_CLKS = 208320,
    parameter logic [31:0] FTW_DEFAULT  = 32'h0000_0000,
    parameter logic [7:0]  AMP_DEFAULT  = 8'hFF
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic [31:0] o_Ftw,
    output logic [7:0]  o_Amp,
    output logic        o_Enable,
    output logic        o_Update,
    output logic        o_Frame_Err,
    output logic [7:0]  o_Err_Count
);
    localparam int             CW   = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_CHK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    sum_q, sum_d;
    logic [31:0]   payload_q, payload_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q;
    logic          timeout, do_write, do_err, cmd_ok;

    assign timeout = (state_q != S_IDLE) && (cnt_q == TERM);
    assign cmd_ok  = (cmd_q == 8'h01) || (cmd_q == 8'h02) || (cmd_q == 8'h03);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        sum_d     = sum_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        do_write  = 1'b0;
        do_err    = 1'b0;
        // A strobe on the terminal-count cycle takes priority over the timeout.
        if (i_Rx_DV) begin
            case (state_q)
                S_IDLE: if (i_Rx_Byte == HEADER) state_d = S_CMD;
                S_CMD: begin
                    cmd_d   = i_Rx_Byte;
                    sum_d   = i_Rx_Byte;
                    idx_d   = 2'd3;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    payload_d = {payload_q[23:0], i_Rx_Byte};
                    sum_d     = sum_q ^ i_Rx_Byte;
                    idx_d     = idx_q - 2'd1;
                    if (idx_q == 2'd0) state_d = S_CHK;
                end
                S_CHK: begin
                    if ((i_Rx_Byte == sum_q) && cmd_ok) do_write = 1'b1;
                    else                                 do_err   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
            do_err  = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            sum_q       <= 8'h00;
            payload_q   <= 32'h0;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            o_Ftw       <= FTW_DEFAULT;
            o_Amp       <= AMP_DEFAULT;
            o_Enable    <= 1'b0;
            o_Update    <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Err_Count <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            sum_q       <= sum_d;
            payload_q   <= payload_d;
            idx_q       <= idx_d;
            o_Update    <= do_write;
            o_Frame_Err <= do_err;
            if (i_Rx_DV || state_q == S_IDLE || timeout) cnt_q <= '0;
            else                                         cnt_q <= cnt_q + 1'b1;
            if (do_write) begin
                case (cmd_q)
                    8'h01:   o_Ftw    <= payload_q;
                    8'h02:   o_Amp    <= payload_q[7:0];
                    8'h03:   o_Enable <= payload_q[0];
                    default: ;
                endcase
            end
            if (do_err && o_Err_Count != 8'hFF) o_Err_Count <= o_Err_Count + 8'h01;
        end
    end
endmodule
